// File: rtl/fifo_lifo_buffer_if.sv
// fifo_lifo_buffer_if: producer/consumer bundle for fifo_lifo_buffer; FIFO_LIFO_ALMOST_EN adds afull/aempty
interface fifo_lifo_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);
    logic             wrn;
    logic             ren;
    logic             mode;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;
`ifdef FIFO_LIFO_ALMOST_EN
    logic             afull;
    logic             aempty;
`endif
    modport master (
        output wrn, ren, mode, in,
        input  out, valid, full, empty, count, ovf, udf
`ifdef FIFO_LIFO_ALMOST_EN
        , input afull, aempty
`endif
    );
    modport slave (
        input  wrn, ren, mode, in,
        output out, valid, full, empty, count, ovf, udf
`ifdef FIFO_LIFO_ALMOST_EN
        , output afull, aempty
`endif
    );
endinterface

// File: rtl/fifo_lifo_buffer.sv
// fifo_lifo_buffer: run-time selectable FIFO/LIFO register buffer; FIFO_LIFO_ALMOST_EN adds afull/aempty
module fifo_lifo_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
`ifdef FIFO_LIFO_ALMOST_EN
    ,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
`endif
) (
    input logic clk,
    input logic rst,
    fifo_lifo_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp, top, wa, ra;
    logic             mode_q, rd_ok, wr_ok;
    assign bus.full  = bus.count == CW'(DEPTH);
    assign bus.empty = bus.count == '0;
`ifdef FIFO_LIFO_ALMOST_EN
    assign bus.afull  = bus.count >= CW'(AF_LVL);
    assign bus.aempty = bus.count <= CW'(AE_LVL);
`endif
    assign rd_ok = bus.ren & ~bus.empty;
    assign wr_ok = bus.wrn & (~bus.full | rd_ok);
    // stack top sits one below the occupancy; a push that coincides with a pop replaces the top
    assign top = bus.count[PW-1:0] - PW'(1);
    assign wa  = mode_q ? (rd_ok ? top : bus.count[PW-1:0]) : wp;
    assign ra  = mode_q ? top : rp;
    // control state: occupancy, pointers, registered read data and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.count <= '0;
            bus.out   <= '0;
            bus.valid <= 1'b0;
            bus.ovf   <= 1'b0;
            bus.udf   <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            mode_q    <= 1'b0;
        end else begin
            bus.count <= bus.count + CW'(wr_ok) - CW'(rd_ok);
            bus.valid <= rd_ok;
            bus.ovf   <= bus.wrn & ~wr_ok;
            bus.udf   <= bus.ren & bus.empty;
            if (rd_ok) bus.out <= mem[ra];
            if (!mode_q && wr_ok) wp <= wp + PW'(1);
            if (!mode_q && rd_ok) rp <= rp + PW'(1);
            if (bus.empty && !bus.wrn) mode_q <= bus.mode;
        end
    end
    // storage array, deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wa] <= bus.in;
    end
endmodule
